// File: rtl/gpio_serial_xfer_ctrl.sv
// Loads the per-pad GPIO config words into the two serial config chains; bit-bang pins take priority.
// Optional build macro GPIO_XFER_IRQ_EN adds irq_clr / xfer_irq (sticky completion interrupt).
module gpio_serial_xfer_ctrl #(
    parameter int IO_CTRL_BITS = 13,
    parameter int NUM_PADS     = 19,
    parameter int CLK_DIV      = 2,
    localparam int IDX_W       = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    xfer_start,
    output logic                    busy,
    output logic                    xfer_done,
    output logic [IDX_W-1:0]        cfg_idx,
    input  logic [IO_CTRL_BITS-1:0] cfg_data_1,
    input  logic [IO_CTRL_BITS-1:0] cfg_data_2,
`ifdef GPIO_XFER_IRQ_EN
    input  logic                    irq_clr,
    output logic                    xfer_irq,
`endif
    input  logic                    bb_enable,
    input  logic                    bb_clock,
    input  logic                    bb_load,
    input  logic                    bb_resetn,
    input  logic                    bb_data_1,
    input  logic                    bb_data_2,
    output logic                    serial_clock,
    output logic                    serial_load,
    output logic                    serial_resetn,
    output logic                    serial_data_1,
    output logic                    serial_data_2,
    output logic [2:0]              dbg_state
);

    localparam int BIT_W = (IO_CTRL_BITS > 1) ? $clog2(IO_CTRL_BITS) : 1;
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(IO_CTRL_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PADS - 1);
    localparam logic [DIV_W-1:0] DIV_END  = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD, DONE} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sclk_q, sclk_d;
    logic             sload_q, sload_d;
    logic             srstn_q, srstn_d;
    logic             sdat1_q, sdat1_d;
    logic             sdat2_q, sdat2_d;
    logic             div_last;

    assign div_last = (div_q == DIV_END);

    // Handshake: xfer_start is a one-cycle request accepted only when idle and bit-bang is off;
    // busy acknowledges it from the next cycle until the cycle after xfer_done.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (xfer_start) begin
                    state_d = SHIFT_LO;
                    div_d   = '0;
                    bit_d   = BIT_MSB;
                    idx_d   = IDX_LAST;
                    last_d  = 1'b0;
                end
            end
            SHIFT_LO: begin
                if (div_last) begin
                    state_d = SHIFT_HI;
                    div_d   = '0;
                    // cfg_data is combinational from cfg_idx, so the next word is selected while the
                    // current word's last bit is on the clock-high phase and its data is already held.
                    if (bit_q == '0) begin
                        if (idx_q == '0) last_d = 1'b1;
                        else             idx_d  = idx_q - IDX_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            SHIFT_HI: begin
                if (div_last) begin
                    div_d = '0;
                    if (bit_q != '0) begin
                        bit_d   = bit_q - BIT_W'(1);
                        state_d = SHIFT_LO;
                    end else if (last_q) begin
                        state_d = LOAD;
                    end else begin
                        bit_d   = BIT_MSB;
                        state_d = SHIFT_LO;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            LOAD: begin
                if (div_last) begin
                    state_d = DONE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = IDX_LAST;
                last_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        // Bit-bang owns the pins: any running transfer is dropped without a load strobe.
        if (bb_enable) begin
            state_d = IDLE;
            div_d   = '0;
            idx_d   = IDX_LAST;
            last_d  = 1'b0;
        end
    end

    always_comb begin
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        sclk_d  = (state_d == SHIFT_HI);
        sload_d = (state_d == LOAD);
        srstn_d = 1'b1;
        sdat1_d = 1'b0;
        sdat2_d = 1'b0;
        if (state_d == SHIFT_LO && state_q != SHIFT_LO) begin
            sdat1_d = cfg_data_1[bit_d];
            sdat2_d = cfg_data_2[bit_d];
        end else if (state_d == SHIFT_LO || state_d == SHIFT_HI) begin
            sdat1_d = sdat1_q;
            sdat2_d = sdat2_q;
        end
        if (bb_enable) begin
            sclk_d  = bb_clock;
            sload_d = bb_load;
            srstn_d = bb_resetn;
            sdat1_d = bb_data_1;
            sdat2_d = bb_data_2;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= BIT_MSB;
            idx_q   <= IDX_LAST;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            sload_q <= 1'b0;
            srstn_q <= 1'b0;
            sdat1_q <= 1'b0;
            sdat2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            sload_q <= sload_d;
            srstn_q <= srstn_d;
            sdat1_q <= sdat1_d;
            sdat2_q <= sdat2_d;
        end
    end

`ifdef GPIO_XFER_IRQ_EN
    logic irq_q, irq_d;

    // Set has priority over a same-cycle clear; aborted transfers never reach DONE.
    always_comb begin
        irq_d = (state_d == DONE) | (irq_q & ~irq_clr);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) irq_q <= 1'b0;
        else          irq_q <= irq_d;
    end

    assign xfer_irq = irq_q;
`endif

    assign busy          = busy_q;
    assign xfer_done     = done_q;
    assign cfg_idx       = idx_q;
    assign serial_clock  = sclk_q;
    assign serial_load   = sload_q;
    assign serial_resetn = srstn_q;
    assign serial_data_1 = sdat1_q;
    assign serial_data_2 = sdat2_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_gpio_serial_xfer_ctrl.sv
// Scoreboard bench for gpio_serial_xfer_ctrl: chain shift-register model checked at each load strobe.
module tb_gpio_serial_xfer_ctrl;
    localparam int IO_CTRL_BITS = 13;
    localparam int NUM_PADS     = 19;
    localparam int CLK_DIV      = 2;
    localparam int CHAIN        = NUM_PADS * IO_CTRL_BITS;
    localparam int BUSY_CYC     = CHAIN * 2 * CLK_DIV + CLK_DIV + 1;

    logic clk, wb_rst_i, xfer_start, busy, xfer_done;
    logic [4:0] cfg_idx;
    logic [IO_CTRL_BITS-1:0] cfg_data_1, cfg_data_2;
    logic bb_enable, bb_clock, bb_load, bb_resetn, bb_data_1, bb_data_2;
    logic serial_clock, serial_load, serial_resetn, serial_data_1, serial_data_2;
    logic [2:0] dbg_state;
`ifdef GPIO_XFER_IRQ_EN
    logic irq_clr, xfer_irq;
`endif

    logic [IO_CTRL_BITS-1:0] mem1 [0:31];
    logic [IO_CTRL_BITS-1:0] mem2 [0:31];
    assign cfg_data_1 = mem1[cfg_idx];
    assign cfg_data_2 = mem2[cfg_idx];

    gpio_serial_xfer_ctrl dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .xfer_start(xfer_start), .busy(busy),
        .xfer_done(xfer_done), .cfg_idx(cfg_idx), .cfg_data_1(cfg_data_1), .cfg_data_2(cfg_data_2),
`ifdef GPIO_XFER_IRQ_EN
        .irq_clr(irq_clr), .xfer_irq(xfer_irq),
`endif
        .bb_enable(bb_enable), .bb_clock(bb_clock), .bb_load(bb_load), .bb_resetn(bb_resetn),
        .bb_data_1(bb_data_1), .bb_data_2(bb_data_2), .serial_clock(serial_clock),
        .serial_load(serial_load), .serial_resetn(serial_resetn), .serial_data_1(serial_data_1),
        .serial_data_2(serial_data_2), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int done_seen = 0;
    int done_exp = 0;
    int viol = 0;

    logic [CHAIN-1:0] exp_c1_q[$];
    logic [CHAIN-1:0] exp_c2_q[$];
    logic [15:0]      exp_busy_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    initial begin : monitor
        logic [CHAIN-1:0] sr1, sr2, e1, e2;
        logic prev_clk, prev_load, prev_busy, prev_bb, prev_d1, prev_d2;
        int cyc, busy_cnt, busy_rise, last_rise, rises, nshift;
        sr1 = '0; sr2 = '0;
        prev_clk = 0; prev_load = 0; prev_busy = 0; prev_bb = 0; prev_d1 = 0; prev_d2 = 0;
        cyc = 0; busy_cnt = 0; busy_rise = 0; last_rise = 0; rises = 0; nshift = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (busy && !prev_busy) begin
                busy_rise = cyc; busy_cnt = 0; rises = 0; nshift = 0;
            end
            if (busy) busy_cnt++;
            if (!busy && prev_busy) begin
                if (exp_busy_q.size() == 0) begin
                    tests_run++; tests_failed++;
                    $display("FAIL busy_unexpected: got length %0d expected none", busy_cnt);
                end else begin
                    check("busy_len", busy_cnt, 32'(exp_busy_q.pop_front()));
                end
            end
            if (serial_clock && !prev_clk) begin
                sr1 = {sr1[CHAIN-2:0], serial_data_1};
                sr2 = {sr2[CHAIN-2:0], serial_data_2};
                nshift++;
                if (busy && !bb_enable) begin
                    if (rises == 0) check("first_rise", cyc - busy_rise, CLK_DIV);
                    else if (cyc - last_rise != 2 * CLK_DIV) viol++;
                    rises++;
                    last_rise = cyc;
                end
            end
            if (prev_clk && serial_clock && !bb_enable && !prev_bb &&
                (serial_data_1 != prev_d1 || serial_data_2 != prev_d2)) viol++;
            if (serial_load && !prev_load && !bb_enable) begin
                if (exp_c1_q.size() == 0) begin
                    tests_run++; tests_failed++;
                    $display("FAIL load_unexpected: got a load strobe expected none");
                end else begin
                    e1 = exp_c1_q.pop_front();
                    e2 = exp_c2_q.pop_front();
                    tests_run++;
                    if (sr1 !== e1) begin
                        tests_failed++;
                        $display("FAIL chain1: got %h expected %h", sr1, e1);
                    end
                    tests_run++;
                    if (sr2 !== e2) begin
                        tests_failed++;
                        $display("FAIL chain2: got %h expected %h", sr2, e2);
                    end
                    check("shift_count", nshift, CHAIN);
                end
            end
            if (xfer_done) done_seen++;
            prev_clk = serial_clock; prev_load = serial_load; prev_busy = busy;
            prev_bb = bb_enable; prev_d1 = serial_data_1; prev_d2 = serial_data_2;
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_words(input bit rnd, input logic [IO_CTRL_BITS-1:0] v1, input logic [IO_CTRL_BITS-1:0] v2);
        for (int p = 0; p < 32; p++) begin
            mem1[p] = rnd ? IO_CTRL_BITS'($urandom_range(0, (1 << IO_CTRL_BITS) - 1)) : v1;
            mem2[p] = rnd ? IO_CTRL_BITS'($urandom_range(0, (1 << IO_CTRL_BITS) - 1)) : v2;
        end
    endtask

    // Highest position is shifted first, so after a full pass it sits at the far end of the chain.
    task automatic push_full();
        logic [CHAIN-1:0] e1, e2;
        for (int p = 0; p < NUM_PADS; p++) begin
            e1[p*IO_CTRL_BITS +: IO_CTRL_BITS] = mem1[p];
            e2[p*IO_CTRL_BITS +: IO_CTRL_BITS] = mem2[p];
        end
        exp_c1_q.push_back(e1);
        exp_c2_q.push_back(e2);
        exp_busy_q.push_back(16'(BUSY_CYC));
        done_exp++;
    endtask

    task automatic pulse_start();
        xfer_start = 1'b1;
        tick(1);
        xfer_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick(1);
            n++;
        end
        check("idle_timeout", busy, 0);
        tick(2);
    endtask

    task automatic irq_after_done();
`ifdef GPIO_XFER_IRQ_EN
        check("irq_set", xfer_irq, 1);
        irq_clr = 1'b1;
        tick(1);
        irq_clr = 1'b0;
        check("irq_clr", xfer_irq, 0);
`endif
    endtask

    initial begin : stimulus
        wb_rst_i = 1'b1; xfer_start = 1'b0;
        bb_enable = 0; bb_clock = 0; bb_load = 0; bb_resetn = 0; bb_data_1 = 0; bb_data_2 = 0;
`ifdef GPIO_XFER_IRQ_EN
        irq_clr = 1'b0;
`endif
        load_words(1'b0, 13'h1809, 13'h0403);
        tick(5);
        check("rst_busy", busy, 0);
        check("rst_done", xfer_done, 0);
        check("rst_idx", cfg_idx, NUM_PADS - 1);
        check("rst_pins", {serial_clock, serial_load, serial_data_1, serial_data_2}, 0);
        check("rst_resetn", serial_resetn, 0);
`ifdef GPIO_XFER_IRQ_EN
        check("rst_irq", xfer_irq, 0);
`endif
        wb_rst_i = 1'b0;
        tick(1);
        check("resetn_release", serial_resetn, 1);

        // start request while bit-bang owns the pins is dropped
        bb_enable = 1'b1; bb_resetn = 1'b1;
        tick(1);
        pulse_start();
        tick(2);
        check("bb_start_ignored", busy, 0);
        bb_enable = 1'b0;
        tick(2);

        // full transfer with fixed words
        push_full();
        pulse_start();
        check("busy_rise", busy, 1);
        wait_idle(BUSY_CYC + 50);
        check("idle_idx", cfg_idx, NUM_PADS - 1);
        irq_after_done();

        // second start at cycle 100 is ignored
        push_full();
        pulse_start();
        tick(99);
        pulse_start();
        wait_idle(BUSY_CYC + 50);
        irq_after_done();

        // bit-bang abort at cycle 300
        load_words(1'b1, '0, '0);
        exp_busy_q.push_back(16'd300);
        pulse_start();
        tick(299);
        bb_clock = 1'b1; bb_data_1 = 1'b1; bb_enable = 1'b1;
        tick(1);
        check("bb_clock", serial_clock, 1);
        check("bb_data1", serial_data_1, 1);
        check("bb_busy", busy, 0);
        check("bb_load", serial_load, 0);
        tick(3);
        bb_enable = 1'b0;
        tick(1);
        check("bb_exit_pins", {serial_clock, serial_load, serial_data_1, serial_data_2}, 0);
        check("bb_exit_resetn", serial_resetn, 1);
        bb_clock = 1'b0; bb_data_1 = 1'b0;
`ifdef GPIO_XFER_IRQ_EN
        check("abort_irq", xfer_irq, 0);
`endif
        tick(2);

        // reset at cycle 500
        exp_busy_q.push_back(16'd500);
        pulse_start();
        tick(500);
        wb_rst_i = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_pins", {serial_clock, serial_load, serial_data_1, serial_data_2}, 0);
        check("midrst_resetn", serial_resetn, 0);
        check("midrst_idx", cfg_idx, NUM_PADS - 1);
        tick(2);
        wb_rst_i = 1'b0;
        tick(2);

        // randomized full transfers
        for (int t = 0; t < 3; t++) begin
            push_full();
            pulse_start();
            wait_idle(BUSY_CYC + 50);
            irq_after_done();
            tick(int'($urandom_range(1, 5)));
        end

        tick(5);
        check("pending_loads", exp_c1_q.size(), 0);
        check("pending_busy", exp_busy_q.size(), 0);
        check("done_count", done_seen, done_exp);
        check("timing_violations", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/gpio_serial_xfer_ctrl.md
Name: gpio_serial_xfer_ctrl

Overview:
Sequencer that loads the 13-bit per-pad GPIO configuration words into the two serial configuration chains: user 1 (mprj_io 0-18) and user 2 (mprj_io 19-37). It sits in housekeeping between the GPIO config register array and the chain pins (serial_clock, serial_load, serial_resetn, serial_data_1, serial_data_2). It runs an automatic transfer on request. It arbitrates the chain pins between that transfer engine and the SPI/wishbone bit-bang register; bit-bang has priority.

Parameters:
IO_CTRL_BITS, 13, config bits per pad.
NUM_PADS, 19, pads per chain; both chains are the same length.
CLK_DIV, 2, wb_clk_i cycles per serial_clock half-period; must be >= 1.

Ports:
wb_clk_i  input  1  system clock; the only clock.
wb_rst_i  input  1  asynchronous, active-high reset.
xfer_start  input  1  single-cycle request to start an automatic transfer.
busy  output  1  high while an automatic transfer is in progress.
xfer_done  output  1  one-cycle pulse when a transfer completes normally.
cfg_idx  output  clog2(NUM_PADS)  chain position whose word is being shifted.
cfg_data_1  input  IO_CTRL_BITS  word for chain 1 at cfg_idx; combinational, valid in the same cycle.
cfg_data_2  input  IO_CTRL_BITS  word for chain 2 at cfg_idx.
bb_enable  input  1  bit-bang mode select.
bb_clock, bb_load, bb_resetn, bb_data_1, bb_data_2  input  1 each  bit-bang pin values.
serial_clock  output  1  chain shift clock.
serial_load  output  1  chain load strobe.
serial_resetn  output  1  chain reset, active low.
serial_data_1  output  1  chain 1 data.
serial_data_2  output  1  chain 2 data.

Behaviour:
- All outputs are registered.
- Reset values:
  - busy, xfer_done, serial_clock, serial_load, serial_data_1, serial_data_2: 0.
  - cfg_idx: NUM_PADS-1.
  - serial_resetn: 0, then 1 on the first clock edge after reset deasserts (auto mode).
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LOAD, DONE.
- IDLE:
  - If xfer_start=1 and bb_enable=0: go to SHIFT_LO, set busy=1, cfg_idx=NUM_PADS-1, bit=IO_CTRL_BITS-1.
  - If xfer_start=1 and bb_enable=1: the request is ignored.
- SHIFT_LO:
  - Drive serial_clock=0, serial_data_1=cfg_data_1[bit], serial_data_2=cfg_data_2[bit].
  - Hold for CLK_DIV cycles, then go to SHIFT_HI.
- SHIFT_HI:
  - Drive serial_clock=1 with data unchanged; hold CLK_DIV cycles.
  - Then advance: decrement bit; when bit wraps from 0, set bit=IO_CTRL_BITS-1 and decrement cfg_idx.
  - After bit 0 of cfg_idx 0, go to LOAD; otherwise go to SHIFT_LO.
- Shift order:
  - Highest chain position first; MSB first within each word.
  - Data changes only while serial_clock=0.
- LOAD: serial_clock=0, serial_load=1, serial_data_*=0; hold CLK_DIV cycles.
- DONE:
  - serial_load=0, xfer_done=1 for one cycle.
  - Next cycle: IDLE, busy=0, cfg_idx=NUM_PADS-1.
- Latency:
  - busy rises the cycle after xfer_start is sampled.
  - busy stays high for NUM_PADS*IO_CTRL_BITS*2*CLK_DIV + CLK_DIV + 1 cycles (991 at defaults).
  - First serial_clock rising edge is CLK_DIV cycles after busy rises.
- xfer_start while busy: ignored; the transfer is neither restarted nor queued.
- Bit-bang arbitration:
  - While bb_enable=1, every serial_* output equals the matching bb_* input, delayed one cycle.
  - Rising bb_enable during a transfer aborts it:
    - FSM returns to IDLE; busy drops the next cycle.
    - No serial_load pulse and no xfer_done.
  - Falling bb_enable:
    - serial_clock=0, serial_load=0, serial_data_*=0, serial_resetn=1 (auto-mode idle values).
- serial_resetn is 1 at all times in auto mode; only reset or bit-bang drives it low.
- wb_rst_i mid-transfer: asynchronously forces reset values with no partial load; a later xfer_start runs a full transfer.

Optional Feature:
Macro: GPIO_XFER_IRQ_EN.
- With the macro: adds port irq_clr (input, 1) and port xfer_irq (output, 1, reset 0).
  - xfer_irq is set in the DONE cycle and holds until irq_clr=1.
  - If DONE and irq_clr occur in the same cycle, set wins.
  - An aborted transfer does not set xfer_irq.
- Without the macro: neither port exists; behaviour is otherwise identical.

Test Plan:
- Reset: hold wb_rst_i for 5 cycles. Expect all outputs at their reset values; serial_resetn=1 one cycle after release; busy=0.
- Full transfer at defaults:
  - Stimulus: chain 1 words all 13'h1809, chain 2 words all 13'h0403.
  - A 247-bit shift-register model per chain, latched on serial_load, holds the correct word at every position.
  - busy stays high exactly 991 cycles; exactly one xfer_done.
- Start while busy: second xfer_start at cycle 100 of a transfer. Expect busy still 991 cycles, one xfer_done, chain contents unchanged from the single-transfer case.
- Bit-bang abort:
  - Raise bb_enable at cycle 300 with bb_clock=1, bb_data_1=1.
  - Expect serial_clock=1 and serial_data_1=1 the next cycle; busy=0; no serial_load; no xfer_done.
  - Drop bb_enable: outputs return to idle values.
- Reset mid-transfer: assert wb_rst_i at cycle 500. Expect immediate reset values and no load pulse; a following xfer_start completes in 991 cycles with correct contents.
- CLK_DIV=1 build: busy high for 496 cycles and serial_clock period of 2 cycles. With GPIO_XFER_IRQ_EN, xfer_irq=1 after DONE and cleared by a one-cycle irq_clr.
